// File: rtl/wino_tile_transpose_if.sv
// Row-in / column-out handshake bundle for the Winograd 6x6 tile transpose buffer.
// The master side is the surrounding pipeline: it drives rows upstream and accepts columns downstream.
interface wino_tile_transpose_if #(
    parameter int data_width = 23
);
    // valid/ready: a row (column) moves on a rising clk edge where valid && ready;
    // valid, once raised, holds with stable data until that edge.
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] din0, din1, din2, din3, din4, din5;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] dout0, dout1, dout2, dout3, dout4, dout5;
    logic [2:0]            out_col;
    logic                  out_last;

    modport master (
        output in_valid, din0, din1, din2, din3, din4, din5, out_ready,
        input  in_ready, out_valid, dout0, dout1, dout2, dout3, dout4, dout5, out_col, out_last
    );

    modport slave (
        input  in_valid, din0, din1, din2, din3, din4, din5, out_ready,
        output in_ready, out_valid, dout0, dout1, dout2, dout3, dout4, dout5, out_col, out_last
    );
endinterface

// File: rtl/wino_tile_transpose.sv
// Ping-pong 6x6 transpose buffer between the row and column passes of the Winograd F(4,3) input transform.
// Rows are written into one bank while the other bank is read out column by column; data passes bit-exact.
module wino_tile_transpose #(
    parameter int data_width = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    wino_tile_transpose_if.slave   bus
);
    logic [data_width-1:0] mem [2][6][6];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [2:0]            wr_row;
    logic [2:0]            rd_col;
    logic                  in_ready;
    logic                  out_valid;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_tile_done;
    logic                  rd_tile_done;
    logic [data_width-1:0] col [6];

    assign in_ready     = !full[wr_bank];
    assign out_valid    = full[rd_bank];
    assign wr_fire      = bus.in_valid && in_ready;
    assign rd_fire      = out_valid && bus.out_ready;
    assign wr_tile_done = wr_fire && (wr_row == 3'd5);
    assign rd_tile_done = rd_fire && (rd_col == 3'd5);

    // Set and clear never hit the same bank: writes target a non-full bank, reads a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_col  <= 3'd0;
        end else begin
            if (wr_fire) begin
                if (wr_tile_done) begin
                    wr_row         <= 3'd0;
                    full[wr_bank]  <= 1'b1;
                    wr_bank        <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 3'd1;
                end
            end
            if (rd_fire) begin
                if (rd_tile_done) begin
                    rd_col         <= 3'd0;
                    full[rd_bank]  <= 1'b0;
                    rd_bank        <= ~rd_bank;
                end else begin
                    rd_col <= rd_col + 3'd1;
                end
            end
        end
    end

    // Tile storage carries no reset; the full flags alone decide what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_row][0] <= bus.din0;
            mem[wr_bank][wr_row][1] <= bus.din1;
            mem[wr_bank][wr_row][2] <= bus.din2;
            mem[wr_bank][wr_row][3] <= bus.din3;
            mem[wr_bank][wr_row][4] <= bus.din4;
            mem[wr_bank][wr_row][5] <= bus.din5;
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            col[k] = '0;
            if (out_valid) col[k] = mem[rd_bank][k][rd_col];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.dout0     = col[0];
    assign bus.dout1     = col[1];
    assign bus.dout2     = col[2];
    assign bus.dout3     = col[3];
    assign bus.dout4     = col[4];
    assign bus.dout5     = col[5];
    assign bus.out_col   = out_valid ? rd_col : 3'd0;
    assign bus.out_last  = out_valid && (rd_col == 3'd5);
endmodule

// File: tb/tb_wino_tile_transpose.sv
// Randomized scoreboard bench for wino_tile_transpose: tiles are pushed as expected columns
// when issued, and a negedge monitor pops and compares every accepted column.
module tb_wino_tile_transpose;
    localparam int W  = 23;
    localparam int CW = 6 * W + 3;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    wino_tile_transpose_if #(.data_width(W)) bus ();
    wino_tile_transpose #(.data_width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [CW-1:0] exp_q [$];
    int            pop_cyc [$];
    int            errors = 0;
    int            checks = 0;
    int            stall_cnt = 0;
    logic [W-1:0]  tile [6][6];
    logic          hold = 1'b0;
    logic [CW-1:0] held;
    bit            rand_done;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic finish_now(input string why);
        errors++;
        checks++;
        $display("FAIL %s: bound expired (cycle %0d)", why, cycle);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "aborted");
    endtask

    function automatic logic [CW-1:0] dut_col();
        return {bus.dout5, bus.dout4, bus.dout3, bus.dout2, bus.dout1, bus.dout0, bus.out_col};
    endfunction

    // Reference: column c of a tile is element c of every row, row 0 in the low slot.
    task automatic push_tile();
        logic [CW-1:0] e;
        for (int c = 0; c < 6; c++) begin
            e = '0;
            for (int k = 0; k < 6; k++) e[3 + k*W +: W] = tile[k][c];
            e[2:0] = 3'(c);
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_tile();
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 6; k++) tile[r][k] = W'($urandom);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the row.
    task automatic send_row(input int r);
        logic acc;
        int   t;
        bus.din0 = tile[r][0]; bus.din1 = tile[r][1]; bus.din2 = tile[r][2];
        bus.din3 = tile[r][3]; bus.din4 = tile[r][4]; bus.din5 = tile[r][5];
        bus.in_valid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) finish_now("row_accept_timeout");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_tile(input int gap);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
            send_row(r);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 600) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare accepted columns, idle zeros, and stability of held columns.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (hold) check("hold_stable", {bus.out_valid, dut_col()}, {1'b1, held});
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_column: got %0h expected none", dut_col());
                    end else begin
                        logic [CW-1:0] e;
                        e = exp_q.pop_front();
                        check("column", dut_col(), e);
                        check("out_last", bus.out_last, (e[2:0] == 3'd5));
                    end
                    pop_cyc.push_back(cycle);
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = dut_col();
                end
            end else begin
                check("idle_zero", {bus.out_last, dut_col()}, '0);
                hold = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        finish_now("global_timeout");
    end

    initial begin
        logic [W-1:0] vals [4];
        vals[0] = 23'h7FFFFF; vals[1] = 23'h400000; vals[2] = 23'h000001; vals[3] = 23'h000000;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0; bus.din4 = '0; bus.din5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_outputs", {bus.out_last, dut_col()}, '0);
        rst = 1'b0;

        // Single known tile: element (r,k) = 16r+k.
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 6; k++) tile[r][k] = W'(16*r + k);
        push_tile();
        bus.out_ready = 1'b1;
        for (int r = 0; r < 5; r++) send_row(r);
        check("latency_early", bus.out_valid, 0);
        send_row(5);
        check("latency_valid", bus.out_valid, 1);
        check("first_column", dut_col(), {W'(80), W'(64), W'(48), W'(32), W'(16), W'(0), 3'd0});
        drain();
        check("valid_falls", bus.out_valid, 0);

        // Back-to-back streaming of 4 tiles.
        pop_cyc.delete();
        stall_cnt = 0;
        for (int t = 0; t < 4; t++) begin
            rand_tile();
            push_tile();
            send_tile(0);
        end
        drain();
        check("stream_no_stall", stall_cnt, 0);
        check("stream_columns", pop_cyc.size(), 24);
        if (pop_cyc.size() == 24) check("stream_no_bubble", pop_cyc[23] - pop_cyc[0], 23);

        // Backpressure: two tiles fill both banks, a third is refused until a bank frees.
        bus.out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            rand_tile();
            push_tile();
            send_tile(0);
        end
        check("bp_full_ready", bus.in_ready, 0);
        rand_tile();
        push_tile();
        bus.din0 = tile[0][0]; bus.din1 = tile[0][1]; bus.din2 = tile[0][2];
        bus.din3 = tile[0][3]; bus.din4 = tile[0][4]; bus.din5 = tile[0][5];
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_blocked", bus.in_ready, 0);
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_still_blocked", bus.in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("bp_ready_return", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int r = 1; r < 6; r++) send_row(r);
        drain();

        // Random stalls on both sides over 20 tiles.
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 20; t++) begin
                    rand_tile();
                    push_tile();
                    send_tile(2);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset with one full tile pending and a partial tile in flight.
        bus.out_ready = 1'b0;
        rand_tile();
        push_tile();
        send_tile(0);
        rand_tile();
        for (int r = 0; r < 3; r++) send_row(r);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_in_ready", bus.in_ready, 1);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_outputs", {bus.out_last, dut_col()}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_tile();
        push_tile();
        bus.out_ready = 1'b1;
        send_tile(0);
        drain();

        // Bit-exact extremes at transposed positions.
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 6; k++) tile[r][k] = vals[(r + 2*k) % 4];
        push_tile();
        send_tile(1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
